ts4231_pulse_capture: RTL and testbench
=======================================

// Module: ts4231_pulse_capture
// PURPOSE
// - Receive side of the TS4231 E line: after the sensor is configured, timestamp each envelope light pulse and measure its width.
// - Sits between the sensor pad and the lighthouse decoder; each record is handed downstream over valid/ready.
// PARAMETERS
// - TS_W          32   width of the free-running timestamp counter (wraps)
// - WIDTH_W       16   width of the pulse-width counter (saturates)
// - MIN_WIDTH     8    pulses shorter than this many cycles are glitches and are discarded
// - E_ACTIVE      0    E level meaning "light present"
// - SYNC_MIN      4800 width in cycles at or above which a pulse is a sync pulse (50 us @ 96 MHz)
// PORTS
// - clk_96MHz      in   1        system clock
// - reset_n        in   1        asynchronous, active-low reset
// - configured     in   1        high once the TS4231 is in WATCH state; capture is enabled only while high
// - e_in           in   1        raw E pad input, asynchronous to clk_96MHz
// - pulse_valid    out  1        record available
// - pulse_ready    in   1        downstream accepts the record when valid & ready
// - pulse_start    out  TS_W     timestamp of the synchronized leading edge
// - pulse_width    out  WIDTH_W  pulse length in cycles, saturated at all-ones
// - pulse_class    out  2        0 = sweep, 1 = sync, 2 = saturated width (only with the macro; otherwise 0)
// - drop_count     out  8        records lost while the output buffer was occupied (saturating)
// BEHAVIOUR
// - Reset: all outputs 0; FSM in IDLE; timestamp counter 0.
// - e_in passes through a 2-FF synchronizer. Edge detection uses the synchronized value, so recorded edges lag the pad by 2 cycles (constant, not compensated).
// - Timestamp counter increments every cycle and wraps from 2^TS_W-1 to 0. pulse_start may therefore exceed the end timestamp.
// - FSM IDLE:
//   - Stays in IDLE while configured=0.
//   - On a synchronized active level with configured=1: latch the current timestamp into pulse_start_q, load width=1, go to ACTIVE.
// - FSM ACTIVE:
//   - Increments width each cycle while E is active; width holds at all-ones once saturated.
//   - When E returns inactive, go to IDLE.
//   - If width >= MIN_WIDTH, emit a record in that same cycle. pulse_valid rises on the next cycle.
//   - If width < MIN_WIDTH, discard silently.
// - Output buffer (1 entry):
//   - Loaded when it is empty, or when pulse_valid & pulse_ready in the same cycle (simultaneous accept + load is allowed).
//   - Otherwise the new record is dropped and drop_count increments, stopping at 255.
//   - pulse_valid stays high with the record held stable until accepted.
// - Abort and re-arm:
//   - configured falls during ACTIVE: abort, go to IDLE, emit nothing, drop_count unchanged.
//   - A pulse already active when configured rises is ignored until E goes inactive. The FSM arms only after an inactive sample.
// - Back-to-back pulses with a single inactive cycle between them are two separate records.
// - reset_n asserted mid-pulse or with a record pending: everything clears immediately and the pending record is lost.
// CONFIGURATION
// - TS4231_PULSE_CLASS_EN defined: pulse_class is computed from the final width and registered with the record.
//   - 2 if width is saturated, else 1 if width >= SYNC_MIN, else 0.
// - Not defined: pulse_class is tied to 2'b00 and the compare logic is absent.
// STRUCTURE
// - ts4231_pkg.vh holds:
//   - class codes PCLASS_SWEEP, PCLASS_SYNC, PCLASS_SAT
//   - FSM state encodings ST_IDLE, ST_ACTIVE
//   - default TS_W and WIDTH_W
// - One sub-module, ts4231_sync2: 2-FF synchronizer with reset_n, reset value = inactive level (!E_ACTIVE).
// - FSM, counters and output buffer live in this module.
// TESTING
// - Single pulse, configured=1: E low for 100 cycles -> one record, pulse_width=100, pulse_start = counter at sync edge, pulse_valid 1 cycle after the end edge.
// - Glitch: E low for 7 cycles (MIN_WIDTH=8) -> no record, drop_count=0; E low for 8 cycles -> one record, width=8.
// - Backpressure: pulse_ready=0, three pulses -> first record held stable, drop_count=2; ready=1 -> first record accepted, valid falls.
// - Simultaneous accept + load: ready rises in the same cycle a second pulse ends -> old record accepted, new record valid next cycle, drop_count unchanged.
// - Abort: configured falls 50 cycles into a pulse -> no record. Start with E held low before configured rises -> no record until E goes high, then low again.
// - Macro on, WIDTH_W=8: pulses of 300, 6000 and 100 cycles -> pulse_width 255 (class 2), 255 (class 2), 100 (class 0); SYNC_MIN=200 with width 220 -> class 1.

Source files
------------

// File: rtl/ts4231_pkg.sv
// ts4231_pkg: shared definitions for the TS4231 E-line pulse capture block.
//   - pclass_e : record classification codes (sweep / sync / saturated width)
//   - state_e  : capture FSM state encodings
//   - TS_W_DEF / WIDTH_W_DEF : default timestamp and width counter widths
package ts4231_pkg;

  localparam int TS_W_DEF    = 32;
  localparam int WIDTH_W_DEF = 16;

  typedef enum logic [1:0] {
    PCLASS_SWEEP = 2'd0,
    PCLASS_SYNC  = 2'd1,
    PCLASS_SAT   = 2'd2
  } pclass_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_e;

endpackage

// File: rtl/ts4231_sync2.sv
// ts4231_sync2: two-flop synchronizer for an asynchronous single-bit input.
// Ports:
//   clk_i  - destination clock
//   rst_ni - asynchronous active-low reset; both flops reset to RST_VAL
//   d_i    - asynchronous input
//   q_o    - synchronized output (2-cycle latency)
module ts4231_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/ts4231_pulse_capture.sv
// ts4231_pulse_capture: timestamps and measures envelope pulses on the TS4231
// E line once the sensor is configured, and hands one record at a time
// downstream through a single-entry output buffer.
//
// Optional feature: define TS4231_PULSE_CLASS_EN to compute pulse_class from
// the final width (2 = saturated, 1 = width >= SYNC_MIN, 0 = sweep). Without
// it pulse_class is tied to 0.
//
// Ports:
//   clk_96MHz   - system clock
//   reset_n     - asynchronous active-low reset
//   configured  - capture enabled while high (sensor in WATCH state)
//   e_in        - raw E pad, asynchronous
//   pulse_valid - record available
//   pulse_ready - downstream accepts the record
//   pulse_start - timestamp of the synchronized leading edge
//   pulse_width - pulse length in cycles, saturating at all-ones
//   pulse_class - record class (see above)
//   drop_count  - records lost to a full buffer, saturating at 255
//   dbg_state   - current capture FSM state
//
// Handshake: a record transfers on any rising clock edge where pulse_valid
// and pulse_ready are both high. While pulse_valid is high and pulse_ready is
// low, the record fields are held stable. A new record may load in the same
// cycle the old one is accepted.
module ts4231_pulse_capture
  import ts4231_pkg::*;
#(
  parameter int   TS_W      = TS_W_DEF,
  parameter int   WIDTH_W   = WIDTH_W_DEF,
  parameter int   MIN_WIDTH = 8,
  parameter logic E_ACTIVE  = 1'b0,
  parameter int   SYNC_MIN  = 4800
) (
  input  logic               clk_96MHz,
  input  logic               reset_n,
  input  logic               configured,
  input  logic               e_in,
  output logic               pulse_valid,
  input  logic               pulse_ready,
  output logic [TS_W-1:0]    pulse_start,
  output logic [WIDTH_W-1:0] pulse_width,
  output logic [1:0]         pulse_class,
  output logic [7:0]         drop_count,
  output state_e             dbg_state
);

  logic e_sync;
  logic e_act;

  ts4231_sync2 #(.RST_VAL(~E_ACTIVE)) u_sync (
    .clk_i  (clk_96MHz),
    .rst_ni (reset_n),
    .d_i    (e_in),
    .q_o    (e_sync)
  );

  assign e_act = (e_sync == E_ACTIVE);

  state_e             state_q, state_d;
  logic [TS_W-1:0]    ts_q;
  logic [TS_W-1:0]    run_start_q, run_start_d;
  logic [WIDTH_W-1:0] width_q, width_d;
  logic               armed_q, armed_d;
  logic               emit;
  logic [31:0]        width_ext;

  logic               valid_q, valid_d;
  logic [TS_W-1:0]    buf_start_q;
  logic [WIDTH_W-1:0] buf_width_q;
  logic [7:0]         drop_q, drop_d;
  logic               load;

  assign width_ext = 32'(width_q);

  // Armed only after an inactive sample seen while configured, so a pulse
  // already in progress when configured rises is never captured half-way.
  always_comb begin
    state_d     = state_q;
    width_d     = width_q;
    run_start_d = run_start_q;
    emit        = 1'b0;
    armed_d     = configured & (armed_q | ~e_act);
    case (state_q)
      ST_IDLE: begin
        if (configured && armed_q && e_act) begin
          state_d     = ST_ACTIVE;
          width_d     = WIDTH_W'(1);
          run_start_d = ts_q;
        end
      end
      ST_ACTIVE: begin
        if (!configured) begin
          state_d = ST_IDLE;
        end else if (e_act) begin
          if (width_q != '1) width_d = width_q + 1'b1;
        end else begin
          state_d = ST_IDLE;
          emit    = (width_ext >= 32'(MIN_WIDTH));
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output buffer: load when empty or being drained this cycle.
  always_comb begin
    load    = emit && (!valid_q || pulse_ready);
    valid_d = valid_q;
    drop_d  = drop_q;
    if (valid_q && pulse_ready) valid_d = 1'b0;
    if (load) valid_d = 1'b1;
    if (emit && !load && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
  end

  always_ff @(posedge clk_96MHz or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      ts_q        <= '0;
      run_start_q <= '0;
      width_q     <= '0;
      armed_q     <= 1'b0;
      valid_q     <= 1'b0;
      buf_start_q <= '0;
      buf_width_q <= '0;
      drop_q      <= '0;
    end else begin
      state_q     <= state_d;
      ts_q        <= ts_q + 1'b1;
      run_start_q <= run_start_d;
      width_q     <= width_d;
      armed_q     <= armed_d;
      valid_q     <= valid_d;
      drop_q      <= drop_d;
      if (load) begin
        buf_start_q <= run_start_q;
        buf_width_q <= width_q;
      end
    end
  end

`ifdef TS4231_PULSE_CLASS_EN
  pclass_e cls_new;
  pclass_e cls_q;

  always_comb begin
    cls_new = PCLASS_SWEEP;
    if (width_q == '1) cls_new = PCLASS_SAT;
    else if (width_ext >= 32'(SYNC_MIN)) cls_new = PCLASS_SYNC;
  end

  always_ff @(posedge clk_96MHz or negedge reset_n) begin
    if (!reset_n) cls_q <= PCLASS_SWEEP;
    else if (load) cls_q <= cls_new;
  end

  assign pulse_class = cls_q;
`else
  assign pulse_class = 2'b00;
`endif

  assign pulse_valid = valid_q;
  assign pulse_start = buf_start_q;
  assign pulse_width = buf_width_q;
  assign drop_count  = drop_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_ts4231_pulse_capture.sv
// tb_ts4231_pulse_capture: directed bench for ts4231_pulse_capture.
// Instance a uses default parameters; instance b uses TS_W=8, WIDTH_W=8,
// SYNC_MIN=200 to reach timestamp wrap and width saturation. Both see the
// same stimulus and share pulse_ready.
module tb_ts4231_pulse_capture;
  import ts4231_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic configured = 1'b0;
  logic e_in = 1'b1;
  logic pulse_ready = 1'b0;

  logic        a_valid, b_valid;
  logic [31:0] a_start;
  logic [7:0]  b_start;
  logic [15:0] a_width;
  logic [7:0]  b_width;
  logic [1:0]  a_class, b_class;
  logic [7:0]  a_drop, b_drop;
  state_e      a_state, b_state;

`ifdef TS4231_PULSE_CLASS_EN
  localparam logic CLS_EN = 1'b1;
`else
  localparam logic CLS_EN = 1'b0;
`endif

  ts4231_pulse_capture dut_a (
    .clk_96MHz(clk), .reset_n(reset_n), .configured(configured), .e_in(e_in),
    .pulse_valid(a_valid), .pulse_ready(pulse_ready), .pulse_start(a_start),
    .pulse_width(a_width), .pulse_class(a_class), .drop_count(a_drop),
    .dbg_state(a_state)
  );

  ts4231_pulse_capture #(.TS_W(8), .WIDTH_W(8), .SYNC_MIN(200)) dut_b (
    .clk_96MHz(clk), .reset_n(reset_n), .configured(configured), .e_in(e_in),
    .pulse_valid(b_valid), .pulse_ready(pulse_ready), .pulse_start(b_start),
    .pulse_width(b_width), .pulse_class(b_class), .drop_count(b_drop),
    .dbg_state(b_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // Reference cycle counter: the expected timestamp timeline.
  logic [31:0] cyc;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cyc <= '0;
    else cyc <= cyc + 32'd1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: sim time expired, got running expected finished");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];   // expected start stamps of pulses in the current test

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // ---------------- driver tasks (call on a negedge) ----------------
  // Holds E active for n cycles; records the expected leading-edge stamp,
  // which is the timestamp in the cycle the synchronized edge appears.
  task automatic pulse(input int n);
    e_in = 1'b0;
    @(negedge clk);
    @(negedge clk);
    exp_q.push_back(cyc);
    repeat (n - 2) @(negedge clk);
    e_in = 1'b1;
  endtask

  task automatic idle(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic accept();
    pulse_ready = 1'b1;
    @(negedge clk);
    pulse_ready = 1'b0;
  endtask

  int          sat_len [4] = '{300, 6000, 100, 220};
  logic [15:0] sat_aw  [4] = '{16'd300, 16'd6000, 16'd100, 16'd220};
  logic [7:0]  sat_bw  [4] = '{8'd255, 8'd255, 8'd100, 8'd220};
  logic [1:0]  sat_ac  [4];
  logic [1:0]  sat_bc  [4];

  // ---------------- directed sequence ----------------
  initial begin
    sat_ac = '{2'd0, (CLS_EN ? 2'd1 : 2'd0), 2'd0, 2'd0};
    sat_bc = '{(CLS_EN ? 2'd2 : 2'd0), (CLS_EN ? 2'd2 : 2'd0), 2'd0, (CLS_EN ? 2'd1 : 2'd0)};

    // Reset state
    idle(2);
    check("rst_valid", a_valid, 0);
    check("rst_start", a_start, 0);
    check("rst_width", a_width, 0);
    check("rst_class", a_class, 0);
    check("rst_drop", a_drop, 0);
    check("rst_state", a_state, ST_IDLE);
    reset_n = 1'b1;
    idle(2);
    configured = 1'b1;
    idle(3);

    // Single 100-cycle pulse
    exp_q.delete();
    pulse(100);
    idle(2);
    check("single_valid_early", a_valid, 0);
    idle(1);
    check("single_valid", a_valid, 1);
    check("single_width", a_width, 100);
    check("single_start", a_start, exp_q[0]);
    check("single_class", a_class, 0);
    check("single_b_start", b_start, exp_q[0][7:0]);
    accept();
    check("single_accepted", a_valid, 0);
    idle(3);

    // Glitch rejection and minimum width
    exp_q.delete();
    pulse(7);
    idle(5);
    check("glitch7_valid", a_valid, 0);
    check("glitch7_drop", a_drop, 0);
    pulse(8);
    idle(3);
    check("min8_valid", a_valid, 1);
    check("min8_width", a_width, 8);
    check("min8_start", a_start, exp_q[1]);
    accept();
    idle(3);

    // Backpressure: three pulses, first held, two dropped
    exp_q.delete();
    pulse(20); idle(4);
    pulse(30); idle(4);
    pulse(40); idle(4);
    check("bp_valid", a_valid, 1);
    check("bp_width", a_width, 20);
    check("bp_start", a_start, exp_q[0]);
    check("bp_drop", a_drop, 2);
    accept();
    check("bp_accepted", a_valid, 0);
    idle(3);

    // Simultaneous accept + load
    exp_q.delete();
    pulse(12); idle(4);
    check("sim_first_width", a_width, 12);
    pulse(15);
    idle(2);
    check("sim_hold_width", a_width, 12);
    check("sim_hold_valid", a_valid, 1);
    pulse_ready = 1'b1;
    @(negedge clk);
    pulse_ready = 1'b0;
    check("sim_new_valid", a_valid, 1);
    check("sim_new_width", a_width, 15);
    check("sim_new_start", a_start, exp_q[1]);
    check("sim_drop", a_drop, 2);
    accept();
    check("sim_accepted", a_valid, 0);
    idle(3);

    // Abort: configured falls mid-pulse
    e_in = 1'b0;
    idle(50);
    configured = 1'b0;
    idle(20);
    e_in = 1'b1;
    idle(5);
    check("abort_valid", a_valid, 0);
    check("abort_drop", a_drop, 2);
    check("abort_state", a_state, ST_IDLE);

    // Pulse already active when configured rises
    e_in = 1'b0;
    idle(10);
    configured = 1'b1;
    idle(30);
    check("prearm_valid", a_valid, 0);
    check("prearm_state", a_state, ST_IDLE);
    e_in = 1'b1;
    idle(5);
    check("prearm_release_valid", a_valid, 0);
    exp_q.delete();
    pulse(25);
    idle(3);
    check("rearm_valid", a_valid, 1);
    check("rearm_width", a_width, 25);
    check("rearm_start", a_start, exp_q[0]);
    accept();
    idle(3);

    // Back-to-back pulses separated by one inactive cycle
    exp_q.delete();
    pulse(10);
    idle(1);
    pulse(11);
    idle(4);
    check("b2b_width", a_width, 10);
    check("b2b_start", a_start, exp_q[0]);
    check("b2b_drop", a_drop, 3);
    accept();
    check("b2b_accepted", a_valid, 0);
    idle(3);

    // drop_count saturation
    for (int i = 0; i < 260; i++) begin
      pulse(8);
      idle(1);
    end
    idle(4);
    check("dropsat_a", a_drop, 255);
    check("dropsat_b", b_drop, 255);
    check("dropsat_width", a_width, 8);
    accept();
    check("dropsat_accepted", a_valid, 0);
    idle(3);

    // Reset with a record pending and a pulse in progress
    pulse(20);
    idle(4);
    e_in = 1'b0;
    idle(10);
    reset_n = 1'b0;
    #1;
    check("midrst_valid", a_valid, 0);
    check("midrst_drop", a_drop, 0);
    check("midrst_width", a_width, 0);
    check("midrst_start", a_start, 0);
    check("midrst_state", a_state, ST_IDLE);
    @(negedge clk);
    reset_n = 1'b1;
    e_in = 1'b1;
    idle(5);
    check("postrst_valid", a_valid, 0);

    // Width saturation, classification, timestamp wrap on instance b
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      pulse(sat_len[i]);
      idle(3);
      check($sformatf("sat%0d_a_width", i), a_width, sat_aw[i]);
      check($sformatf("sat%0d_a_class", i), a_class, sat_ac[i]);
      check($sformatf("sat%0d_b_valid", i), b_valid, 1);
      check($sformatf("sat%0d_b_width", i), b_width, sat_bw[i]);
      check($sformatf("sat%0d_b_class", i), b_class, sat_bc[i]);
      check($sformatf("sat%0d_b_start", i), b_start, exp_q[i][7:0]);
      accept();
      idle(2);
    end
    check("sat_b_drop", b_drop, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
